// File: rtl/rsa_modexp_if.sv
// Handshake and operand bus for the modular-exponentiation core.
// master drives the request (start, base, exponent, N) and receives the
// completion side (busy, valid, err, result); slave is the core's view.
interface rsa_modexp_if #(
    parameter int unsigned W = 16
);
    logic         start;
    logic [W-1:0] base;
    logic [W-1:0] exponent;
    logic [W-1:0] N;
    logic         busy;
    logic         valid;
    logic         err;
    logic [W-1:0] result;

    modport master (
        output start, base, exponent, N,
        input  busy, valid, err, result
    );

    modport slave (
        input  start, base, exponent, N,
        output busy, valid, err, result
    );
endinterface

// File: rtl/rsa_modexp_core.sv
// Constant-time modular exponentiation: result = base^exponent mod N.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - rsa_modexp_if.slave: start/base/exponent/N in,
//          busy/valid/err/result out (all outputs registered)
// Schedule: LOAD, REDUCE (W cycles), then W x (SQR + MUL, W cycles each),
// DONE. Every multiply runs the full W cycles whatever the operands.
module rsa_modexp_core #(
    parameter int unsigned W = 16
) (
    input  logic        clk,
    input  logic        rst,
    rsa_modexp_if.slave bus
);
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned RW = W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REDUCE, S_SQR, S_MUL, S_DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [W-1:0]  r_base, r_exp, r_n, r_acc, r_b, r_t, r_result;
    logic [W-1:0]  w_base_next, w_exp_next, w_n_next, w_acc_next;
    logic [W-1:0]  w_b_next, w_t_next, w_result_next;
    logic [RW-1:0] r_r, w_r_next;
    logic [CW-1:0] r_cnt, r_idx, w_cnt_next, w_idx_next;
    logic          r_busy, r_valid, r_err, r_bad;
    logic          w_busy_next, w_valid_next, w_err_next, w_bad_next;

    // Shared interleaved multiplier: R <- 2R + a_j*x, then up to two subtracts of N
    logic [W-1:0]  w_mul_a, w_mul_x;
    logic          w_abit;
    logic [RW-1:0] w_n_ext, w_sum, w_s1, w_s2;

    always_comb begin
        w_mul_a = r_base;
        w_mul_x = W'(1);
        case (r_state)
            S_SQR: begin
                w_mul_a = r_acc;
                w_mul_x = r_acc;
            end
            S_MUL: begin
                w_mul_a = r_t;
                w_mul_x = r_b;
            end
            default: ;
        endcase
        w_abit  = w_mul_a[r_cnt];
        w_n_ext = RW'(r_n);
        w_sum   = {r_r[RW-2:0], 1'b0} + (w_abit ? RW'(w_mul_x) : RW'(0));
        w_s1    = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
        w_s2    = (w_s1 >= w_n_ext) ? (w_s1 - w_n_ext) : w_s1;
    end

    // Next-state and datapath update
    always_comb begin
        w_state_next  = r_state;
        w_base_next   = r_base;
        w_exp_next    = r_exp;
        w_n_next      = r_n;
        w_acc_next    = r_acc;
        w_b_next      = r_b;
        w_t_next      = r_t;
        w_result_next = r_result;
        w_r_next      = r_r;
        w_cnt_next    = r_cnt;
        w_idx_next    = r_idx;
        w_busy_next   = r_busy;
        w_valid_next  = 1'b0;
        w_err_next    = r_err;
        w_bad_next    = r_bad;

        case (r_state)
            S_IDLE: begin
                // a start coinciding with the valid strobe is not accepted
                if (bus.start && !r_valid) begin
                    w_base_next  = bus.base;
                    w_exp_next   = bus.exponent;
                    w_n_next     = bus.N;
                    w_busy_next  = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_r_next   = '0;
                w_cnt_next = CW'(W - 1);
                w_idx_next = CW'(W - 1);
                if (r_n < W'(2)) begin
                    w_bad_next   = 1'b1;
                    w_acc_next   = '0;
                    w_state_next = S_DONE;
                end else begin
                    w_bad_next   = 1'b0;
                    w_acc_next   = W'(1);
                    w_state_next = S_REDUCE;
                end
            end
            S_REDUCE, S_SQR, S_MUL: begin
                w_r_next   = w_s2;
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    w_r_next   = '0;
                    w_cnt_next = CW'(W - 1);
                    if (r_state == S_REDUCE) begin
                        w_b_next     = w_s2[W-1:0];
                        w_state_next = S_SQR;
                    end else if (r_state == S_SQR) begin
                        w_t_next     = w_s2[W-1:0];
                        w_state_next = S_MUL;
                    end else begin
                        // multiply always runs; the exponent bit only selects
                        w_acc_next = r_exp[r_idx] ? w_s2[W-1:0] : r_t;
                        if (r_idx == '0) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_idx_next   = r_idx - CW'(1);
                            w_state_next = S_SQR;
                        end
                    end
                end
            end
            S_DONE: begin
                w_result_next = r_bad ? '0 : r_acc;
                w_err_next    = r_bad;
                w_valid_next  = 1'b1;
                w_busy_next   = 1'b0;
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_n      <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_t      <= '0;
            r_result <= '0;
            r_r      <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_base   <= w_base_next;
            r_exp    <= w_exp_next;
            r_n      <= w_n_next;
            r_acc    <= w_acc_next;
            r_b      <= w_b_next;
            r_t      <= w_t_next;
            r_result <= w_result_next;
            r_r      <= w_r_next;
            r_cnt    <= w_cnt_next;
            r_idx    <= w_idx_next;
            r_busy   <= w_busy_next;
            r_valid  <= w_valid_next;
            r_err    <= w_err_next;
            r_bad    <= w_bad_next;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.valid  = r_valid;
    assign bus.err    = r_err;
    assign bus.result = r_result;
endmodule
